// File: rtl/polyphase_decimator.sv
// Decimating polyphase FIR: RATE_CHANGE samples in, one sample out, single time-multiplexed signed MAC.
// Optional macro POLYPHASE_DECIMATOR_SATURATE_EN: saturate the output instead of two's-complement wrap.
module polyphase_decimator #(
  parameter int unsigned NUMBER_TAPS       = 32,
  parameter int unsigned DATA_IN_WIDTH     = 16,
  parameter int unsigned DATA_OUT_WIDTH    = 16,
  parameter int unsigned COEFFICIENT_WIDTH = 16,
  parameter int unsigned RATE_CHANGE       = 8,
  parameter int unsigned OUTPUT_SHIFT      = 15
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  output logic                             data_in_tready,
  input  logic [DATA_IN_WIDTH-1:0]         data_in_tdata,
  input  logic                             data_in_tlast,
  input  logic                             data_in_tvalid,
  input  logic                             data_out_tready,
  output logic [DATA_OUT_WIDTH-1:0]        data_out_tdata,
  output logic                             data_out_tlast,
  output logic                             data_out_tvalid,
  input  logic                             coeffs_wren,
  input  logic [$clog2(NUMBER_TAPS)-1:0]   coeffs_addr,
  input  logic [COEFFICIENT_WIDTH-1:0]     coeffs_wdata
);
  localparam int unsigned TAP_W   = $clog2(NUMBER_TAPS);
  localparam int unsigned PHASE_W = $clog2(RATE_CHANGE);
  localparam int unsigned CNT_W   = TAP_W + 1;
  localparam int unsigned PROD_W  = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
  localparam int unsigned ACC_W   = PROD_W + TAP_W;

  typedef enum logic [1:0] {S_FILL, S_MAC, S_OUT} state_e;

  state_e                                          state_q, state_d;
  logic [PHASE_W-1:0]                              phase_q, phase_d;
  logic                                            last_q, last_d;
  logic [CNT_W-1:0]                                mac_cnt_q, mac_cnt_d;
  logic [NUMBER_TAPS-1:0][DATA_IN_WIDTH-1:0]       hist_q, hist_d;
  logic [NUMBER_TAPS-1:0][COEFFICIENT_WIDTH-1:0]   coef_q, coef_d;
  logic signed [PROD_W-1:0]                        prod_q, prod_d;
  logic signed [ACC_W-1:0]                         acc_q, acc_d;
  logic [DATA_OUT_WIDTH-1:0]                       out_data_q, out_data_d;
  logic                                            out_last_q, out_last_d;
  logic                                            out_valid_q, out_valid_d;
  logic                                            in_ready_q, in_ready_d;

  logic [TAP_W-1:0]                                tap_idx_c;
  logic signed [ACC_W-1:0]                         final_acc_c;
  logic signed [DATA_OUT_WIDTH-1:0]                reduced_c;

  // Product is pipelined one cycle, so the accumulator trails the tap counter by one.
  assign tap_idx_c   = mac_cnt_q[TAP_W-1:0];
  assign final_acc_c = acc_q + ACC_W'(prod_q);

`ifdef POLYPHASE_DECIMATOR_SATURATE_EN
  logic signed [ACC_W-1:0] hi_c;
  assign hi_c = final_acc_c >>> (OUTPUT_SHIFT + DATA_OUT_WIDTH - 1);

  always_comb begin
    if ((&hi_c) || !(|hi_c)) begin
      reduced_c = DATA_OUT_WIDTH'(final_acc_c >>> OUTPUT_SHIFT);
    end else if (hi_c[ACC_W-1]) begin
      reduced_c = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
    end else begin
      reduced_c = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign reduced_c = DATA_OUT_WIDTH'(final_acc_c >>> OUTPUT_SHIFT);
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    last_d     = last_q;
    mac_cnt_d  = mac_cnt_q;
    hist_d     = hist_q;
    coef_d     = coef_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;

    if (coeffs_wren) begin
      coef_d[coeffs_addr] = coeffs_wdata;
    end

    unique case (state_q)
      S_FILL: begin
        if (data_in_tvalid && in_ready_q) begin
          hist_d = {hist_q[NUMBER_TAPS-2:0], data_in_tdata};
          if ((phase_q == PHASE_W'(RATE_CHANGE - 1)) || data_in_tlast) begin
            phase_d   = '0;
            last_d    = data_in_tlast;
            mac_cnt_d = '0;
            acc_d     = '0;
            prod_d    = '0;
            state_d   = S_MAC;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = final_acc_c;
        if (mac_cnt_q == CNT_W'(NUMBER_TAPS)) begin
          out_data_d = reduced_c;
          out_last_d = last_q;
          state_d    = S_OUT;
        end else begin
          prod_d    = PROD_W'($signed(hist_q[tap_idx_c])) * PROD_W'($signed(coef_q[tap_idx_c]));
          mac_cnt_d = mac_cnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (data_out_tready) begin
          state_d = S_FILL;
          if (last_q) begin
            hist_d = '0;
            last_d = 1'b0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase

    out_valid_d = (state_d == S_OUT);
    in_ready_d  = (state_d == S_FILL);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_FILL;
      phase_q     <= '0;
      last_q      <= 1'b0;
      mac_cnt_q   <= '0;
      hist_q      <= '0;
      coef_q      <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      last_q      <= last_d;
      mac_cnt_q   <= mac_cnt_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign data_in_tready  = in_ready_q;
  assign data_out_tdata  = out_data_q;
  assign data_out_tlast  = out_last_q;
  assign data_out_tvalid = out_valid_q;

endmodule
